// File: rtl/sal_wr_datapath_if.sv
// AXI W/B channel bundle for sal_wr_datapath; master drives W and bready, slave returns wready and B.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_RESP_OKAY
`define AXI_RESP_OKAY 2'b00
`endif

interface sal_wr_datapath_if #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ID_WIDTH   = `AXI_ID_WIDTH
);
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic [ID_WIDTH-1:0]     wid;
    logic                    wlast;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;

    modport master (
        output wvalid, wdata, wstrb, wid, wlast, bready,
        input  wready, bvalid, bid, bresp
    );

    modport slave (
        input  wvalid, wdata, wstrb, wid, wlast, bready,
        output wready, bvalid, bid, bresp
    );
endinterface

// File: rtl/sal_wr_datapath.sv
// Write datapath: buffers AXI W beats, replays them on DFI after wr_gnt + dfi_wren_lat, returns B responses.
// Optional macro SAL_WR_BRESP_DEFER_EN holds each B response until its burst's last beat has left on DFI.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_RESP_OKAY
`define AXI_RESP_OKAY 2'b00
`endif

module sal_wr_datapath #(
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned DEPTH_LG2   = 3,
    parameter int unsigned BURST_BEATS = 2,
    parameter int unsigned ID_WIDTH    = `AXI_ID_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              dfi_wren_lat,
    input  logic                    wr_gnt,
    sal_wr_datapath_if.slave        axi,
    output logic                    wrdata_en,
    output logic [DATA_WIDTH-1:0]   wrdata,
    output logic [DATA_WIDTH/8-1:0] wrdata_mask,
    output logic                    underflow_err
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned DEPTH  = 1 << DEPTH_LG2;
    localparam int unsigned ENT_W  = DATA_WIDTH + STRB_W;
    localparam logic [15:0] BURST_MASK = 16'((1 << BURST_BEATS) - 1);

    // write-data FIFO
    logic [ENT_W-1:0]   dmem [DEPTH];
    logic [DEPTH_LG2:0] dwr_q, dwr_d, drd_q, drd_d;
    logic               dfull, dempty, push, pop;
    logic [ENT_W-1:0]   head;

    // BID FIFO
    logic [ID_WIDTH-1:0] bmem [DEPTH];
    logic [DEPTH_LG2:0]  bwr_q, bwr_d, brd_q, brd_d;
    logic                bfull, bempty, bpush, bpop, bvalid_w;

    logic [15:0] shift_q, shift_d;
    logic [4:0]  tap;
    logic        underflow_q, underflow_d;

    assign dempty = (dwr_q == drd_q);
    assign dfull  = (dwr_q[DEPTH_LG2] != drd_q[DEPTH_LG2]) &&
                    (dwr_q[DEPTH_LG2-1:0] == drd_q[DEPTH_LG2-1:0]);
    assign bempty = (bwr_q == brd_q);
    assign bfull  = (bwr_q[DEPTH_LG2] != brd_q[DEPTH_LG2]) &&
                    (bwr_q[DEPTH_LG2-1:0] == brd_q[DEPTH_LG2-1:0]);

    assign axi.wready = ~dfull & ~bfull;
    assign push       = axi.wvalid & axi.wready;
    assign bpush      = push & axi.wlast;

    // Tap offset by BURST_BEATS-1 so the leading granted beat lands dfi_wren_lat+1 cycles after wr_gnt.
    assign tap       = {1'b0, dfi_wren_lat} + 5'(BURST_BEATS - 1);
    assign wrdata_en = ~tap[4] & shift_q[tap[3:0]];

    assign pop  = wrdata_en & ~dempty;
    assign head = dmem[drd_q[DEPTH_LG2-1:0]];

    // No bypass: an empty FIFO always yields zero data, fully masked.
    assign wrdata      = pop ? head[ENT_W-1:STRB_W] : '0;
    assign wrdata_mask = pop ? head[STRB_W-1:0]     : '1;

    assign bpop      = bvalid_w & axi.bready;
    assign axi.bvalid = bvalid_w;
    assign axi.bid    = bmem[brd_q[DEPTH_LG2-1:0]];
    assign axi.bresp  = `AXI_RESP_OKAY;

    assign underflow_err = underflow_q;

    always_comb begin
        shift_d = {shift_q[14:0], 1'b0};
        if (wr_gnt) begin
            shift_d = shift_d | BURST_MASK;
        end
        dwr_d       = push  ? dwr_q + 1'b1 : dwr_q;
        drd_d       = pop   ? drd_q + 1'b1 : drd_q;
        bwr_d       = bpush ? bwr_q + 1'b1 : bwr_q;
        brd_d       = bpop  ? brd_q + 1'b1 : brd_q;
        underflow_d = underflow_q | (wrdata_en & dempty);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q     <= '0;
            dwr_q       <= '0;
            drd_q       <= '0;
            bwr_q       <= '0;
            brd_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            dwr_q       <= dwr_d;
            drd_q       <= drd_d;
            bwr_q       <= bwr_d;
            brd_q       <= brd_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dmem[dwr_q[DEPTH_LG2-1:0]] <= {axi.wdata, ~axi.wstrb};
        end
        if (bpush) begin
            bmem[bwr_q[DEPTH_LG2-1:0]] <= axi.wid;
        end
    end

`ifdef SAL_WR_BRESP_DEFER_EN
    logic               last_mem [DEPTH];
    logic [DEPTH_LG2:0] retire_q, retire_d;
    logic               retire_inc;

    assign retire_inc = pop & last_mem[drd_q[DEPTH_LG2-1:0]];
    assign bvalid_w   = ~bempty & (retire_q != '0);

    always_comb begin
        retire_d = retire_q;
        case ({retire_inc, bpop})
            2'b10:   retire_d = retire_q + 1'b1;
            2'b01:   retire_d = retire_q - 1'b1;
            default: retire_d = retire_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            last_mem[dwr_q[DEPTH_LG2-1:0]] <= axi.wlast;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end
`else
    assign bvalid_w = ~bempty;
`endif

endmodule

// File: tb/tb_sal_wr_datapath.sv
// Directed bench for sal_wr_datapath: per-cycle vector table plus hand sequences for full, B hold,
// underflow and mid-burst reset. Expected bvalid timing follows SAL_WR_BRESP_DEFER_EN when defined.
`timescale 1ns/1ps
module tb_sal_wr_datapath;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int IW = 4;
`ifdef SAL_WR_BRESP_DEFER_EN
    localparam bit DEFER = 1'b1;
`else
    localparam bit DEFER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    lat;
    logic          wr_gnt;
    logic          wrdata_en;
    logic [DW-1:0] wrdata;
    logic [SW-1:0] wrdata_mask;
    logic          underflow_err;

    always #5 clk = ~clk;

    sal_wr_datapath_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

    sal_wr_datapath #(
        .DATA_WIDTH (DW),
        .DEPTH_LG2  (3),
        .BURST_BEATS(2),
        .ID_WIDTH   (IW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dfi_wren_lat (lat),
        .wr_gnt       (wr_gnt),
        .axi          (axi),
        .wrdata_en    (wrdata_en),
        .wrdata       (wrdata),
        .wrdata_mask  (wrdata_mask),
        .underflow_err(underflow_err)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          wv;
        logic [DW-1:0] wd;
        logic [SW-1:0] ws;
        logic [IW-1:0] wid;
        logic          wl;
        logic          gnt;
        logic          brdy;
        logic          e_wr;
        logic          e_en;
        logic [DW-1:0] e_d;
        logic [SW-1:0] e_m;
        logic          bv_nd;
        logic          bv_df;
        logic [IW-1:0] e_bid;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t v(logic wv, logic [DW-1:0] wd, logic [SW-1:0] ws, logic [IW-1:0] wid,
                               logic wl, logic gnt, logic brdy, logic e_wr, logic e_en,
                               logic [DW-1:0] e_d, logic [SW-1:0] e_m, logic bv_nd, logic bv_df,
                               logic [IW-1:0] e_bid);
        vec_t r;
        r.wv = wv; r.wd = wd; r.ws = ws; r.wid = wid; r.wl = wl; r.gnt = gnt; r.brdy = brdy;
        r.e_wr = e_wr; r.e_en = e_en; r.e_d = e_d; r.e_m = e_m;
        r.bv_nd = bv_nd; r.bv_df = bv_df; r.e_bid = e_bid;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        axi.wvalid = 1'b0;
        axi.wdata  = '0;
        axi.wstrb  = '0;
        axi.wid    = '0;
        axi.wlast  = 1'b0;
        axi.bready = 1'b0;
        wr_gnt     = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [SW-1:0] s,
                        input logic [IW-1:0] id, input logic l);
        axi.wvalid = 1'b1;
        axi.wdata  = d;
        axi.wstrb  = s;
        axi.wid    = id;
        axi.wlast  = l;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_wrdata_en", wrdata_en, 0);
        chk("rst_bvalid", axi.bvalid, 0);
        chk("rst_underflow", underflow_err, 0);
        chk("rst_wready", axi.wready, 1);
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        logic any_en;
        logic any_bv;

        // wv  wdata          ws    wid   wl g  br | wr en  e_data        e_m   bvnd bvdf bid
        tbl[0]  = v(1, 32'hA0A0_0001, 4'hF, 4'd5, 0, 0, 0, 1, 0, '0,           4'hF, 0, 0, 4'd0);
        tbl[1]  = v(1, 32'hB1B1_0002, 4'h5, 4'd5, 1, 0, 0, 1, 0, '0,           4'hF, 0, 0, 4'd0);
        tbl[2]  = v(0, '0,            4'h0, 4'd0, 0, 0, 0, 1, 0, '0,           4'hF, 1, 0, 4'd5);
        tbl[3]  = v(0, '0,            4'h0, 4'd0, 0, 1, 0, 1, 0, '0,           4'hF, 1, 0, 4'd5);
        tbl[4]  = v(0, '0,            4'h0, 4'd0, 0, 0, 0, 1, 0, '0,           4'hF, 1, 0, 4'd5);
        tbl[5]  = v(0, '0,            4'h0, 4'd0, 0, 0, 0, 1, 0, '0,           4'hF, 1, 0, 4'd5);
        tbl[6]  = v(0, '0,            4'h0, 4'd0, 0, 0, 0, 1, 0, '0,           4'hF, 1, 0, 4'd5);
        tbl[7]  = v(0, '0,            4'h0, 4'd0, 0, 0, 0, 1, 1, 32'hA0A0_0001, 4'h0, 1, 0, 4'd5);
        tbl[8]  = v(0, '0,            4'h0, 4'd0, 0, 0, 0, 1, 1, 32'hB1B1_0002, 4'hA, 1, 0, 4'd5);
        tbl[9]  = v(0, '0,            4'h0, 4'd0, 0, 0, 1, 1, 0, '0,           4'hF, 1, 1, 4'd5);
        tbl[10] = v(1, 32'hC2C2_0003, 4'h3, 4'd3, 0, 0, 0, 1, 0, '0,           4'hF, 0, 0, 4'd0);
        tbl[11] = v(1, 32'hD3D3_0004, 4'h8, 4'd3, 0, 0, 0, 1, 0, '0,           4'hF, 0, 0, 4'd0);
        tbl[12] = v(1, 32'hE4E4_0005, 4'h0, 4'd3, 1, 0, 0, 1, 0, '0,           4'hF, 0, 0, 4'd0);
        tbl[13] = v(0, '0,            4'h0, 4'd0, 0, 1, 0, 1, 0, '0,           4'hF, 1, 0, 4'd3);
        tbl[14] = v(0, '0,            4'h0, 4'd0, 0, 1, 0, 1, 0, '0,           4'hF, 1, 0, 4'd3);
        tbl[15] = v(0, '0,            4'h0, 4'd0, 0, 0, 0, 1, 0, '0,           4'hF, 1, 0, 4'd3);
        tbl[16] = v(0, '0,            4'h0, 4'd0, 0, 0, 0, 1, 0, '0,           4'hF, 1, 0, 4'd3);
        tbl[17] = v(0, '0,            4'h0, 4'd0, 0, 0, 0, 1, 1, 32'hC2C2_0003, 4'hC, 1, 0, 4'd3);
        tbl[18] = v(0, '0,            4'h0, 4'd0, 0, 0, 0, 1, 1, 32'hD3D3_0004, 4'h7, 1, 0, 4'd3);
        tbl[19] = v(0, '0,            4'h0, 4'd0, 0, 0, 0, 1, 1, 32'hE4E4_0005, 4'hF, 1, 0, 4'd3);
        tbl[20] = v(0, '0,            4'h0, 4'd0, 0, 0, 1, 1, 0, '0,           4'hF, 1, 1, 4'd3);
        tbl[21] = v(0, '0,            4'h0, 4'd0, 0, 0, 0, 1, 0, '0,           4'hF, 0, 0, 4'd0);

        lat = 4'd3;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            axi.wvalid = tbl[i].wv;
            axi.wdata  = tbl[i].wd;
            axi.wstrb  = tbl[i].ws;
            axi.wid    = tbl[i].wid;
            axi.wlast  = tbl[i].wl;
            axi.bready = tbl[i].brdy;
            wr_gnt     = tbl[i].gnt;
            @(negedge clk);
            chk($sformatf("row%0d_wready", i), axi.wready, tbl[i].e_wr);
            chk($sformatf("row%0d_wrdata_en", i), wrdata_en, tbl[i].e_en);
            if (tbl[i].e_en) begin
                chk($sformatf("row%0d_wrdata", i), wrdata, tbl[i].e_d);
                chk($sformatf("row%0d_mask", i), wrdata_mask, tbl[i].e_m);
            end
            chk($sformatf("row%0d_bvalid", i), axi.bvalid, DEFER ? tbl[i].bv_df : tbl[i].bv_nd);
            if (DEFER ? tbl[i].bv_df : tbl[i].bv_nd)
                chk($sformatf("row%0d_bid", i), axi.bid, tbl[i].e_bid);
            chk($sformatf("row%0d_underflow", i), underflow_err, 0);
            cyc();
        end
        idle();
        chk("bresp_okay", axi.bresp, 2'b00);

        // Fill all eight entries, then a single grant drains one and reopens wready.
        do_reset();
        lat = 4'd0;
        for (int i = 0; i < 8; i++) begin
            push(32'hF000_0000 + DW'(i), 4'hF, 4'd0, 1'b0);
            @(negedge clk);
            chk($sformatf("fill%0d_wready", i), axi.wready, 1);
            cyc();
        end
        push(32'hDEAD_BEEF, 4'hF, 4'd0, 1'b0);
        @(negedge clk);
        chk("full_wready", axi.wready, 0);
        cyc();
        axi.wvalid = 1'b0;
        wr_gnt     = 1'b1;
        @(negedge clk);
        chk("full_gnt_wready", axi.wready, 0);
        chk("full_gnt_en", wrdata_en, 0);
        cyc();
        wr_gnt = 1'b0;
        @(negedge clk);
        chk("full_pop_en", wrdata_en, 1);
        chk("full_pop_wready", axi.wready, 0);
        chk("full_pop_data", wrdata, 32'hF000_0000);
        cyc();
        @(negedge clk);
        chk("after_pop_wready", axi.wready, 1);
        chk("after_pop_data", wrdata, 32'hF000_0001);
        cyc();

        // B response must hold through back-pressure.
        do_reset();
        lat = 4'd3;
        push(32'h0000_0001, 4'hF, 4'd9, 1'b1);
        cyc();
        idle();
        wr_gnt = 1'b1;
        cyc();
        wr_gnt = 1'b0;
        found  = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (axi.bvalid) found = 1'b1;
            else cyc();
        end
        chk("hold_bvalid_wait", found, 1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d_bvalid", k), axi.bvalid, 1);
            chk($sformatf("hold%0d_bid", k), axi.bid, 4'd9);
            cyc();
            @(negedge clk);
        end
        axi.bready = 1'b1;
        chk("hold_final_bvalid", axi.bvalid, 1);
        cyc();
        axi.bready = 1'b0;
        @(negedge clk);
        chk("hold_done_bvalid", axi.bvalid, 0);

        // Grant against an empty FIFO: zero data, full mask, sticky error, no same-cycle bypass.
        do_reset();
        lat = 4'd2;
        wr_gnt = 1'b1;
        cyc();
        wr_gnt = 1'b0;
        cyc();
        @(negedge clk);
        chk("uf_early_en", wrdata_en, 0);
        cyc();
        @(negedge clk);
        chk("uf_en", wrdata_en, 1);
        chk("uf_data", wrdata, 0);
        chk("uf_mask", wrdata_mask, 4'hF);
        chk("uf_flag_not_yet", underflow_err, 0);
        cyc();
        push(32'h1234_5678, 4'hF, 4'd0, 1'b0);
        @(negedge clk);
        chk("uf_bypass_en", wrdata_en, 1);
        chk("uf_bypass_data", wrdata, 0);
        chk("uf_bypass_mask", wrdata_mask, 4'hF);
        chk("uf_flag_set", underflow_err, 1);
        cyc();
        idle();
        repeat (5) cyc();
        @(negedge clk);
        chk("uf_flag_sticky", underflow_err, 1);
        cyc();

        // Reset in the middle of a DFI burst drops everything in flight.
        do_reset();
        lat = 4'd3;
        push(32'h5555_0001, 4'hF, 4'd2, 1'b0);
        cyc();
        push(32'h5555_0002, 4'hF, 4'd2, 1'b1);
        cyc();
        idle();
        wr_gnt = 1'b1;
        cyc();
        wr_gnt = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk("mid_en_before", wrdata_en, 1);
        rst_n = 1'b0;
        cyc();
        @(negedge clk);
        chk("mid_rst_en", wrdata_en, 0);
        chk("mid_rst_bvalid", axi.bvalid, 0);
        chk("mid_rst_underflow", underflow_err, 0);
        chk("mid_rst_wready", axi.wready, 1);
        cyc();
        rst_n  = 1'b1;
        any_en = 1'b0;
        any_bv = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            any_en |= wrdata_en;
            any_bv |= axi.bvalid;
            cyc();
        end
        chk("post_rst_no_en", any_en, 0);
        chk("post_rst_no_bvalid", any_bv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
